// File: rtl/mem_arbiter_pkg.sv
// Shared encodings and defaults for the fetch/data memory-bus arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_MEM  = 2'd2
  } owner_e;

  localparam int ARB_STARVE_MAX = 4;
  // Wide enough for the full legal STARVE_MAX range of 1..15.
  localparam int STARVE_W = 4;

endpackage

// File: rtl/mem_arbiter_arb_prio.sv
// Fixed data-over-fetch priority with a saturating starvation counter that
// hands the bus to fetch after STARVE_MAX consecutive lost arbitrations.
module arb_prio
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = ARB_STARVE_MAX
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req,
  input  logic mem_req,
  input  logic en,
  output logic grant_if,
  output logic grant_mem
);

  localparam logic [STARVE_W-1:0] STARVE_MAX_C = STARVE_W'(STARVE_MAX);

  logic [STARVE_W-1:0] starve_q;
  logic [STARVE_W-1:0] starve_d;
  logic                force_if;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    force_if  = if_req && (starve_q == STARVE_MAX_C);
    grant_mem = en && mem_req && !force_if;
    grant_if  = en && if_req && !grant_mem;

    starve_d = starve_q;
    if (grant_if) begin
      starve_d = '0;
    end else if (grant_mem && if_req && (starve_q != STARVE_MAX_C)) begin
      starve_d = starve_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its _d value from before the edge, independent of block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory bus between instruction fetch and data access,
// one outstanding transaction at a time, with per-requester stall outputs.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int STARVE_MAX = ARB_STARVE_MAX
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_stall,

  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_wmask,
  output logic              mem_gnt,
  output logic              mem_rvalid,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_stall,

  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic [DATA_W-1:0] bus_wmask,
  input  logic              bus_ready,
  input  logic              bus_rvalid,
  input  logic [DATA_W-1:0] bus_rdata
);

  arb_state_e        state_q, state_d;
  owner_e            owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] wmask_q, wmask_d;

  logic grant_if, grant_mem;
  logic complete;

  // Arbitration is suppressed during reset so no grant escapes the reset cycle.
  arb_prio #(
    .STARVE_MAX (STARVE_MAX)
  ) u_prio (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .mem_req   (mem_req),
    .en        ((state_q == ARB_IDLE) && !rst),
    .grant_if  (grant_if),
    .grant_mem (grant_mem)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB_IDLE: if (grant_if || grant_mem) state_d = ARB_REQ;
      ARB_REQ: begin
        if (bus_ready && bus_rvalid) state_d = ARB_IDLE;
        else if (bus_ready)          state_d = ARB_RESP;
      end
      ARB_RESP: if (bus_rvalid) state_d = ARB_IDLE;
      default: state_d = ARB_IDLE;
    endcase
  end

  // Output logic: a stray bus_rvalid in IDLE or un-accepted REQ never completes.
  always_comb begin
    bus_req  = (state_q == ARB_REQ);
    complete = !rst && (((state_q == ARB_REQ) && bus_ready && bus_rvalid) ||
                        ((state_q == ARB_RESP) && bus_rvalid));
  end

  // Transaction latch: captured only on a win, so later requester changes
  // cannot disturb the fields of the transaction already in flight.
  always_comb begin
    owner_d = owner_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    if (grant_mem) begin
      owner_d = OWN_MEM;
      we_d    = mem_we;
      addr_d  = mem_addr;
      wdata_d = mem_wdata;
      wmask_d = mem_we ? mem_wmask : '0;
    end else if (grant_if) begin
      owner_d = OWN_IF;
      we_d    = 1'b0;
      addr_d  = if_addr;
      wdata_d = '0;
      wmask_d = '0;
    end else if (complete) begin
      owner_d = OWN_NONE;
    end
  end

  // NOTE: the datapath latches are reset along with the control state so the
  // bus fields read as zero straight out of reset, not just bus_req.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q <= OWN_NONE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
    end else begin
      owner_q <= owner_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
    end
  end

  always_comb begin
    bus_we     = we_q;
    bus_addr   = addr_q;
    bus_wdata  = wdata_q;
    bus_wmask  = wmask_q;

    if_gnt     = grant_if;
    mem_gnt    = grant_mem;
    if_rvalid  = complete && (owner_q == OWN_IF);
    mem_rvalid = complete && (owner_q == OWN_MEM);
    if_rdata   = if_rvalid  ? bus_rdata : '0;
    mem_rdata  = mem_rvalid ? bus_rdata : '0;

    if_stall   = if_req  && !if_rvalid;
    mem_stall  = mem_req && !mem_rvalid;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with hand-computed expectations.
module tb_mem_arbiter;

  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt, if_rvalid, if_stall;
  logic [DATA_W-1:0] if_rdata;
  logic              mem_req, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_wmask;
  logic              mem_gnt, mem_rvalid, mem_stall;
  logic [DATA_W-1:0] mem_rdata;
  logic              bus_req, bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata, bus_wmask;
  logic              bus_ready, bus_rvalid;
  logic [DATA_W-1:0] bus_rdata;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .STARVE_MAX (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_gnt     (if_gnt),
    .if_rvalid  (if_rvalid),
    .if_rdata   (if_rdata),
    .if_stall   (if_stall),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wmask  (mem_wmask),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .mem_stall  (mem_stall),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_wmask  (bus_wmask),
    .bus_ready  (bus_ready),
    .bus_rvalid (bus_rvalid),
    .bus_rdata  (bus_rdata)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks happen mid-cycle.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    rst = 1'b1;
    if_req = 1'b0;  if_addr = '0;
    mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wmask = '0;
    bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;

    // Reset state: no grant escapes reset, stall is ungated.
    repeat (2) next_cycle();
    if_req = 1'b1;
    settle();
    check("rst_bus_req", bus_req, 0);
    check("rst_bus_addr", bus_addr, 0);
    check("rst_bus_wmask", bus_wmask, 0);
    check("rst_if_gnt", if_gnt, 0);
    check("rst_if_stall", if_stall, 1);
    check("rst_mem_rvalid", mem_rvalid, 0);
    next_cycle();
    rst = 1'b0; if_req = 1'b0;
    next_cycle();

    // Zero-wait read.
    if_req = 1'b1; if_addr = 64'h8000_0000;
    bus_ready = 1'b1; bus_rvalid = 1'b1; bus_rdata = 64'h1234;
    settle();
    check("zw_if_gnt", if_gnt, 1);
    check("zw_mem_gnt", mem_gnt, 0);
    check("zw_idle_bus_req", bus_req, 0);
    check("zw_idle_rvalid_ignored", if_rvalid, 0);
    next_cycle();
    settle();
    check("zw_bus_req", bus_req, 1);
    check("zw_bus_addr", bus_addr, 64'h8000_0000);
    check("zw_bus_wmask", bus_wmask, 0);
    check("zw_if_rvalid", if_rvalid, 1);
    check("zw_if_rdata", if_rdata, 64'h1234);
    check("zw_if_stall", if_stall, 0);
    check("zw_mem_rvalid", mem_rvalid, 0);
    check("zw_mem_rdata", mem_rdata, 0);
    next_cycle();
    if_req = 1'b0;
    settle();
    check("zw_after_bus_req", bus_req, 0);
    check("zw_after_if_stall", if_stall, 0);
    check("zw_after_if_rvalid", if_rvalid, 0);
    next_cycle();

    // Back-to-back zero-wait fetches: grants two cycles apart.
    if_req = 1'b1; if_addr = 64'h8000_0010; bus_rdata = 64'h1111;
    settle();
    check("b2b_gnt0", if_gnt, 1);
    next_cycle();
    if_addr = 64'h8000_0014;
    settle();
    check("b2b_gnt_gap", if_gnt, 0);
    check("b2b_rvalid0", if_rvalid, 1);
    check("b2b_rdata0", if_rdata, 64'h1111);
    check("b2b_addr0", bus_addr, 64'h8000_0010);
    next_cycle();
    bus_rdata = 64'h2222;
    settle();
    check("b2b_gnt1", if_gnt, 1);
    check("b2b_bubble_bus_req", bus_req, 0);
    check("b2b_bubble_rdata", if_rdata, 0);
    next_cycle();
    settle();
    check("b2b_rvalid1", if_rvalid, 1);
    check("b2b_rdata1", if_rdata, 64'h2222);
    check("b2b_addr1", bus_addr, 64'h8000_0014);
    next_cycle();
    if_req = 1'b0; bus_ready = 1'b0; bus_rvalid = 1'b0;
    settle();
    check("b2b_idle_gnt", if_gnt, 0);
    next_cycle();

    // Contention with a 2-cycle bus: MEM x4, IF, MEM x4, IF.
    if_req = 1'b1; if_addr = 64'h8000_0100;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 64'h8000_3000;
    for (int t = 0; t < 10; t++) begin
      logic exp_if;
      exp_if = (t == 4) || (t == 9);
      bus_ready = 1'b0; bus_rvalid = 1'b0;
      settle();
      check($sformatf("cont%0d_if_gnt", t), if_gnt, exp_if);
      check($sformatf("cont%0d_mem_gnt", t), mem_gnt, !exp_if);
      next_cycle();
      bus_ready = 1'b1;
      settle();
      check($sformatf("cont%0d_addr", t), bus_addr, exp_if ? 64'h8000_0100 : 64'h8000_3000);
      next_cycle();
      bus_ready = 1'b0; bus_rvalid = 1'b1; bus_rdata = 64'h100 + 64'(t);
      settle();
      check($sformatf("cont%0d_if_rvalid", t), if_rvalid, exp_if);
      check($sformatf("cont%0d_mem_rvalid", t), mem_rvalid, !exp_if);
      check($sformatf("cont%0d_rdata", t), exp_if ? if_rdata : mem_rdata, 64'h100 + 64'(t));
      next_cycle();
    end
    if_req = 1'b0; mem_req = 1'b0; bus_rvalid = 1'b0;
    next_cycle();

    // Write with a stalled bus; fetch stays blocked throughout.
    if_req = 1'b1; if_addr = 64'h8000_0200;
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 64'h8000_1008;
    mem_wdata = 64'hAB00; mem_wmask = 64'hFF00;
    settle();
    check("wr_mem_gnt", mem_gnt, 1);
    check("wr_if_gnt", if_gnt, 0);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      bus_rvalid = (i == 0);
      settle();
      check($sformatf("wr_wait%0d_bus_we", i), bus_we, 1);
      check($sformatf("wr_wait%0d_wmask", i), bus_wmask, 64'hFF00);
      check($sformatf("wr_wait%0d_wdata", i), bus_wdata, 64'hAB00);
      check($sformatf("wr_wait%0d_addr", i), bus_addr, 64'h8000_1008);
      check($sformatf("wr_wait%0d_mem_rvalid", i), mem_rvalid, 0);
      check($sformatf("wr_wait%0d_if_stall", i), if_stall, 1);
    end
    next_cycle();
    bus_ready = 1'b1; bus_rvalid = 1'b0;
    settle();
    check("wr_accept_mem_rvalid", mem_rvalid, 0);
    next_cycle();
    bus_ready = 1'b0; bus_rvalid = 1'b1; bus_rdata = '0;
    settle();
    check("wr_ack_mem_rvalid", mem_rvalid, 1);
    check("wr_ack_mem_stall", mem_stall, 0);
    check("wr_ack_if_rvalid", if_rvalid, 0);
    check("wr_ack_if_stall", if_stall, 1);
    next_cycle();
    mem_req = 1'b0; mem_we = 1'b0; bus_ready = 1'b1; bus_rvalid = 1'b1; bus_rdata = 64'h55;
    settle();
    check("wr_then_if_gnt", if_gnt, 1);
    next_cycle();
    settle();
    check("wr_then_if_rdata", if_rdata, 64'h55);
    check("wr_then_if_addr", bus_addr, 64'h8000_0200);
    check("wr_then_if_we", bus_we, 0);
    next_cycle();
    if_req = 1'b0; bus_ready = 1'b0; bus_rvalid = 1'b0;
    next_cycle();

    // Read request fields change after the grant; latched values hold.
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 64'h8000_2000; mem_wmask = 64'hFFFF;
    settle();
    check("chg_mem_gnt", mem_gnt, 1);
    next_cycle();
    mem_addr = '0; mem_we = 1'b1;
    settle();
    check("chg_addr_held", bus_addr, 64'h8000_2000);
    check("chg_we_held", bus_we, 0);
    check("chg_read_mask_zero", bus_wmask, 0);
    next_cycle();
    bus_ready = 1'b1;
    settle();
    check("chg_addr_held_accept", bus_addr, 64'h8000_2000);
    next_cycle();
    bus_ready = 1'b0; bus_rvalid = 1'b1; bus_rdata = 64'hBEEF;
    settle();
    check("chg_mem_rvalid", mem_rvalid, 1);
    check("chg_mem_rdata", mem_rdata, 64'hBEEF);
    check("chg_addr_at_complete", bus_addr, 64'h8000_2000);
    next_cycle();
    mem_req = 1'b0; mem_we = 1'b0; bus_rvalid = 1'b0;
    next_cycle();

    // Reset while awaiting the response; the late response is dropped.
    mem_req = 1'b1; mem_addr = 64'h8000_4000;
    settle();
    check("rr_mem_gnt", mem_gnt, 1);
    next_cycle();
    bus_ready = 1'b1;
    next_cycle();
    bus_ready = 1'b0; rst = 1'b1; mem_req = 1'b0;
    settle();
    check("rr_in_reset_rvalid", mem_rvalid, 0);
    next_cycle();
    rst = 1'b0; bus_rvalid = 1'b1; bus_rdata = 64'hDEAD;
    settle();
    check("rr_late_mem_rvalid", mem_rvalid, 0);
    check("rr_late_if_rvalid", if_rvalid, 0);
    check("rr_late_mem_rdata", mem_rdata, 0);
    check("rr_bus_req", bus_req, 0);
    check("rr_bus_addr", bus_addr, 0);
    next_cycle();
    if_req = 1'b1; if_addr = 64'h8000_0300; bus_ready = 1'b1; bus_rdata = 64'h77;
    settle();
    check("rr_idle_if_gnt", if_gnt, 1);
    check("rr_idle_if_rvalid", if_rvalid, 0);
    next_cycle();
    settle();
    check("rr_if_rvalid", if_rvalid, 1);
    check("rr_if_rdata", if_rdata, 64'h77);
    next_cycle();
    if_req = 1'b0; bus_ready = 1'b0; bus_rvalid = 1'b0;
    next_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port memory bus between the instruction-fetch requester (if_stage) and the data requester (mem stage).
- Allows one outstanding transaction at a time.
- Data requests have fixed priority. A starvation counter periodically forces an instruction grant.
- Produces per-requester stall signals for hazard_unit, replacing the dual-port RAM helper path.

Parameters:
- ADDR_W, 64, address width of requesters and bus.
- DATA_W, 64, data width; the write mask has the same width.
- STARVE_MAX, 4, number of consecutive lost arbitrations after which fetch wins; legal range 1..15.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- if_req  in  1  fetch request; held until if_rvalid
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  one-cycle pulse: fetch request accepted, address latched
- if_rvalid  out  1  fetch read data valid (one cycle)
- if_rdata  out  DATA_W  fetch read data
- if_stall  out  1  if_req & ~if_rvalid
- mem_req  in  1  data request; held until mem_rvalid
- mem_we  in  1  1 = write, 0 = read
- mem_addr  in  ADDR_W  data address
- mem_wdata  in  DATA_W  write data (pre-shifted)
- mem_wmask  in  DATA_W  bit write mask
- mem_gnt  out  1  one-cycle pulse: data request accepted
- mem_rvalid  out  1  read data valid, or write acknowledge (one cycle)
- mem_rdata  out  DATA_W  data read result
- mem_stall  out  1  mem_req & ~mem_rvalid
- bus_req  out  1  request to memory; held until bus_ready
- bus_we  out  1  latched write enable
- bus_addr  out  ADDR_W  latched address
- bus_wdata  out  DATA_W  latched write data
- bus_wmask  out  DATA_W  latched mask; zero for reads
- bus_ready  in  1  memory accepts the request this cycle
- bus_rvalid  in  1  response/acknowledge for the accepted request
- bus_rdata  in  DATA_W  response data

Behaviour:
- State machine with three states: IDLE, REQ, RESP. A latched owner register holds NONE, IF or MEM.
- Reset (rst=1 at a clock edge, including mid-transaction):
  - state=IDLE, owner=NONE, starve_cnt=0.
  - All bus_* outputs are 0.
  - All gnt/rvalid outputs are 0. rdata outputs are 0.
  - A bus_rvalid that arrives after reset for a dropped transaction is ignored, because owner=NONE.
- IDLE arbitration (combinational, gnt pulses in the same cycle):
  - mem_req only -> MEM.
  - if_req only -> IF.
  - Both requesting -> MEM, unless starve_cnt==STARVE_MAX, in which case IF.
  - On a win: latch addr, we, wdata and mask (mask forced to 0 for IF and for reads), set owner, and go to REQ.
- starve_cnt:
  - +1 when both requesters are asserted and MEM wins; saturates at STARVE_MAX.
  - Cleared whenever IF is granted.
  - Otherwise held.
- REQ:
  - bus_req=1 with the latched fields.
  - bus_ready & bus_rvalid in the same cycle -> complete and go to IDLE.
  - bus_ready alone -> RESP.
  - Neither -> stay in REQ.
- RESP: on bus_rvalid -> complete and go to IDLE.
- Complete: the owner's rvalid=1 for exactly that cycle. Its rdata = bus_rdata (combinational pass-through). owner becomes NONE.
  - The non-owner's rvalid stays 0.
  - Both rdata outputs are 0 when not valid.
- Latency:
  - The grant is in cycle N; the earliest rvalid is cycle N+1 (zero-wait bus).
  - IDLE is always visited between transactions, giving 1 bubble cycle; the next grant is at the earliest in the cycle after completion.
- Request inputs that change while a transaction is in flight do not affect the latched bus fields.
- A requester that drops req before rvalid is a protocol violation; the response is still delivered.
- bus_rvalid while in IDLE or REQ-without-ready is ignored.
- if_stall and mem_stall are combinational and are not gated by reset beyond the req inputs.

Decomposition:
- Add to defines.v: ARB_IDLE/ARB_REQ/ARB_RESP 2-bit encodings, OWN_NONE/OWN_IF/OWN_MEM 2-bit encodings, and the ARB_STARVE_MAX default.
- One sub-module, arb_prio, holds the priority select and the saturating starve_cnt. It takes if_req, mem_req, an enable (state==IDLE) and clk/rst, and outputs grant_if/grant_mem.
- The state machine, latches and response routing stay in mem_arbiter.

Test Plan:
- Zero-wait read: if_req=1, if_addr=0x80000000, bus_ready=bus_rvalid=1 in REQ with bus_rdata=0x1234 -> if_gnt at N, bus_req at N+1, if_rvalid=1 and if_rdata=0x1234 at N+1, if_stall low after that.
- Contention: if_req and mem_req both held continuously, with 2-cycle bus response (ready then rvalid) -> grant order MEM,MEM,MEM,MEM,IF,MEM… (STARVE_MAX=4); starve_cnt returns to 0 after the IF grant.
- Write: mem_we=1, mem_addr=0x80001008, mem_wmask=0xFF00, mem_wdata=0xAB00 -> bus_we=1 with latched mask/data while bus_ready is held low for 3 cycles; mem_rvalid pulses once on bus_rvalid; if_req stays blocked (if_stall=1) throughout.
- Reset in RESP: assert rst while awaiting bus_rvalid, then bus_rvalid=1 one cycle after reset -> no rvalid on either port, bus_req=0, state IDLE.
- Input change after grant: mem_addr changes to 0x0 the cycle after mem_gnt -> bus_addr keeps the original latched value until completion.
- Same-cycle ready+rvalid back-to-back: two consecutive IF reads -> exactly one IDLE bubble between them, with if_gnt pulses 2 cycles apart.
